iter_mul_div: RTL and testbench
===============================

# iter_mul_div

- Iterative multiply/divide unit for the LoongArch CPU core, parametrised in operand width `WIDTH`.
- Executes MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU, which the single-cycle ALU does not support.
- It is a one-bit-per-cycle engine behind valid/ready handshakes, with a flush input for pipeline cancellation.
- It sits beside the ALU in the execute stage; the core stalls on `busy` and consumes the result through the response handshake.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be ≥ 4 and even.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  a request is present on `req_op`, `req_src1` and `req_src2`.
- `req_ready`  out  1  unit can accept a request; high only in IDLE and only when `flush` is low.
- `req_op`  in  3  operation select:
  - 000 MUL: low half of the product.
  - 001 MULH: high half, signed.
  - 010 MULHU: high half, unsigned.
  - 011: reserved, executes as MUL.
  - 100 DIV: signed quotient.
  - 101 MOD: signed remainder.
  - 110 DIVU: unsigned quotient.
  - 111 MODU: unsigned remainder.
- `req_src1`  in  WIDTH  multiplicand / dividend.
- `req_src2`  in  WIDTH  multiplier / divisor.
- `resp_valid`  out  1  `resp_result` holds a finished result.
- `resp_ready`  in  1  consumer takes the result.
- `resp_result`  out  WIDTH  result.
- `busy`  out  1  high whenever the state is not IDLE.
- `flush`  in  1  abort any operation in progress and discard its result.

## Operation
- States and transitions:
  - IDLE → CALC on accept (`req_valid && req_ready`).
  - CALC → DONE after the WIDTH-th iteration.
  - DONE → IDLE on `resp_valid && resp_ready`.
- Accept edge actions:
  - Latch the op.
  - Latch operand magnitudes (two's-complement absolute value for signed ops; raw value for unsigned ops).
  - Latch the sign flags.
  - Load the iteration counter with WIDTH-1.
- Multiply:
  - Shift-add over magnitudes into a 2·WIDTH accumulator, one multiplier bit per cycle.
  - Signed MULH: negate the 2·WIDTH product when the operand signs differ.
  - MUL: output the low WIDTH bits.
  - MULH/MULHU: output the high WIDTH bits.
- Divide:
  - Restoring division over magnitudes, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
  - Signed quotient is negated iff the operand signs differ and the divisor is nonzero.
  - Signed remainder takes the sign of the dividend.
- Divisor = 0:
  - DIV and DIVU return all ones.
  - MOD and MODU return `req_src1` unchanged.
  - Same latency as any other operation.
  - No sign correction is applied.
- Signed overflow (MIN / −1):
  - DIV returns MIN (e.g. 0x80000000).
  - MOD returns 0.
- `resp_result` is registered:
  - It is written once, on the CALC→DONE edge.
  - It is held stable while `resp_valid && !resp_ready`.
- `flush`:
  - In any state, the next edge goes to IDLE and `resp_valid` drops.
  - `resp_result` is left unchanged.
  - While `flush` is high, no request is accepted (`req_ready` forced low).
- Reserved op 011 behaves exactly as 000.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 1 (if `flush` is low), `resp_valid` = 0, `busy` = 0.
  - `resp_result` = 0; counter and accumulators = 0.
- Latency:
  - Accept at edge E0; iterations occur at E1…E_WIDTH.
  - `resp_valid` goes high after E_WIDTH: WIDTH cycles, 32 for the default.
- Throughput:
  - The response handshake edge returns the unit to IDLE.
  - The next accept is possible one edge later, so the minimum period is WIDTH+2 cycles.
- The response may sit in DONE indefinitely; `busy` stays high throughout.
- Simultaneous `resp_ready` and `flush` in DONE: both lead to IDLE; the result counts as consumed.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of the clock.

## Test plan
- MUL: 7 × 0xFFFFFFFD (−3) → 0xFFFFFFEB. MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Each asserts `resp_valid` exactly 32 cycles after accept.
- DIV: 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. MOD of the same operands → 0xFFFFFFFF. DIVU: 100 / 7 → 14. MODU: 100 / 7 → 2.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; MOD of the same → 0.
  - DIVU 5 / 0 → 0xFFFFFFFF; MODU 5 / 0 → 5; DIV 0xFFFFFFF9 / 0 → 0xFFFFFFFF.
- Backpressure: hold `resp_ready` low for 10 cycles after `resp_valid`. `resp_result` and `resp_valid` stay stable, and `req_ready` stays low with `req_valid` held high. One cycle after the handshake, the next request is accepted.
- Flush:
  - Pulse `flush` 10 cycles into a DIV: IDLE follows next cycle and no `resp_valid` appears.
  - A request presented during the flush cycle is not accepted.
  - A subsequent MUL 6 × 7 → 42.
- Reset: assert `reset` asynchronously mid-CALC. `busy` and `resp_valid` go to 0 without a clock edge. After release, DIVU 9 / 3 → 3.

Source files
------------

// File: rtl/iter_mul_div.sv
// iter_mul_div: iterative multiply/divide unit for the execute stage.
// One multiplier/quotient bit per cycle over operand magnitudes, with the
// sign fixed up on the final iteration. Valid/ready on both request and
// response; flush cancels whatever is in flight.
module iter_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             busy,
    input  logic             flush
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a_reg;     // multiplicand / dividend (quotient shifts in)
    logic [WIDTH-1:0]   b_reg;     // multiplier (shifts out) / divisor
    logic               sign1;
    logic               sign2;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // product accumulator
    logic [WIDTH-1:0]   rem;       // partial remainder, always < divisor

    // Only MULH, DIV and MOD work on magnitudes; MUL low half is sign-agnostic.
    logic             req_signed;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    assign req_signed = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b101);
    assign neg1       = req_signed && req_src1[WIDTH-1];
    assign neg2       = req_signed && req_src2[WIDTH-1];
    assign mag1       = neg1 ? -req_src1 : req_src1;
    assign mag2       = neg2 ? -req_src2 : req_src2;

    assign req_ready  = (state == IDLE) && !flush;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    // One iteration step for each engine, plus the final sign-corrected result.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH:0]     div_rem_wide;
    logic [WIDTH-1:0]   div_rem_nxt;
    logic [WIDTH-1:0]   div_q_nxt;
    logic [WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]   div_res;
    logic               b_zero;

    assign mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_reg[0] ? a_reg : '0)};
    assign mul_nxt      = {mul_sum, acc[WIDTH-1:1]};
    assign div_trial    = {rem, a_reg[WIDTH-1]};
    assign div_ge       = div_trial >= {1'b0, b_reg};
    assign div_rem_wide = div_ge ? (div_trial - {1'b0, b_reg}) : div_trial;
    assign div_rem_nxt  = div_rem_wide[WIDTH-1:0];
    assign div_q_nxt    = {a_reg[WIDTH-2:0], div_ge};
    assign b_zero       = (b_reg == '0);

    // Result selection on the last iteration. A zero divisor yields an
    // all-ones quotient and the dividend magnitude as remainder; giving that
    // remainder the dividend's sign reproduces src1 exactly (MIN included).
    always_comb begin
        prod    = (op == 3'b001 && (sign1 ^ sign2)) ? -mul_nxt : mul_nxt;
        mul_res = (op == 3'b001 || op == 3'b010) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        if (!op[0])
            div_res = (!op[1] && (sign1 ^ sign2) && !b_zero) ? -div_q_nxt : div_q_nxt;
        else
            div_res = (!op[1] && sign1) ? -div_rem_nxt : div_rem_nxt;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op          <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            sign1       <= 1'b0;
            sign2       <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            rem         <= '0;
            resp_result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state <= CALC;
                    op    <= req_op;
                    a_reg <= mag1;
                    b_reg <= mag2;
                    sign1 <= neg1;
                    sign2 <= neg2;
                    cnt   <= CW'(WIDTH - 1);
                    acc   <= '0;
                    rem   <= '0;
                end
                CALC: begin
                    if (op[2]) begin
                        rem   <= div_rem_nxt;
                        a_reg <= div_q_nxt;
                    end else begin
                        acc   <= mul_nxt;
                        b_reg <= b_reg >> 1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        resp_result <= op[2] ? div_res : mul_res;
                    end
                end
                DONE: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_mul_div.sv
// Self-checking bench for iter_mul_div: directed vector table, randomized
// ops against an arithmetic reference, and backpressure/flush/reset sequences.
module tb_iter_mul_div;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;
    logic        flush;

    int ncmp = 0;
    int nerr = 0;

    iter_mul_div #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic and the documented corner rules.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = int'(a);
        sb = int'(b);
        sp = longint'(sa) * longint'(sb);
        up = {32'b0, a} * {32'b0, b};
        case (op)
            3'd1: return sp[63:32];
            3'd2: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            3'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd7: return (b == 0) ? a : a % b;
            default: return up[31:0];
        endcase
    endfunction

    // Present a request at a falling edge and hold it until the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Starting at the falling edge right after the accept: count edges to resp_valid.
    task automatic wait_resp(output logic [31:0] res, output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("resp_timeout", 32'(resp_valid), 32'd1);
        res = resp_result;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        issue(op, a, b);
        wait_resp(res, lat);
        take_resp();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[14];
        logic [31:0] res;
        logic [31:0] r0;
        int          lat;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[4]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[5]  = '{3'd6, 32'd100,        32'd7,         32'd14};
        vecs[6]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[8]  = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[10] = '{3'd7, 32'd5,          32'd0,         32'd5};
        vecs[11] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{3'd3, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[13] = '{3'd5, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
        resp_ready = 1'b0; flush = 1'b0;
        #12;
        check("reset_busy",        32'(busy),       32'd0);
        check("reset_resp_valid",  32'(resp_valid), 32'd0);
        check("reset_req_ready",   32'(req_ready),  32'd1);
        check("reset_resp_result", resp_result,     32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors, each also checked for 32-cycle latency.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd32);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            do_op(rop, ra, rb, res, lat);
            check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), res, model(rop, ra, rb));
        end

        // Backpressure: result held while resp_ready is low; a waiting request
        // is accepted one cycle after the handshake.
        issue(3'd6, 32'd1000, 32'd10);
        req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd5; req_src2 = 32'd5;
        wait_resp(r0, lat);
        check("bp_first_result", r0, 32'd100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held",   32'(resp_valid), 32'd1);
            check("bp_result_held",  resp_result,     r0);
            check("bp_req_ready_lo", 32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_idle_after_hs", 32'(busy),      32'd0);
        check("bp_ready_after_hs", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_accepted", 32'(busy), 32'd1);
        wait_resp(res, lat);
        check("bp_second_result", res, 32'd25);
        take_resp();

        // Flush mid-DIV; a request offered during the flush cycle is ignored.
        r0 = resp_result;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 9; i++) @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1; req_op = 3'd6; req_src1 = 32'd9; req_src2 = 32'd3;
        check("flush_req_ready_lo", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_idle", 32'(busy), 32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || busy) lat++;
        end
        check("flush_no_activity", 32'(lat), 32'd0);
        check("flush_result_kept", resp_result, r0);
        do_op(3'd0, 32'd6, 32'd7, res, lat);
        check("flush_then_mul", res, 32'd42);

        // Asynchronous reset in the middle of a calculation.
        issue(3'd6, 32'd1000, 32'd7);
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_busy",        32'(busy),       32'd0);
        check("areset_resp_valid",  32'(resp_valid), 32'd0);
        check("areset_resp_result", resp_result,     32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(3'd6, 32'd9, 32'd3, res, lat);
        check("after_reset_divu", res, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
